// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative ALU: opcode constants, FSM states and
// the flag bundle carried alongside each result.
package alu_iter_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
    localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;
    localparam logic [OPC_W-1:0] OP_MUL = 5'b00110;
    localparam logic [OPC_W-1:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic not_equal;
        logic less_than;
        logic overflow;
        logic exception;
    } alu_flags_t;

endpackage

// File: rtl/alu_iter_multdiv_core.sv
// Iterative signed multiply / divide datapath.
//  clock, reset   : clock and asynchronous active-high reset
//  start, op_div  : launch an operation (op_div=1 divide, 0 multiply)
//  operand_a/b    : operands, sampled on start
//  done_c         : high during the final step cycle; result_c/overflow_c are
//                   valid in that same cycle (they are computed from next state)
//  dbz            : divide-by-zero indication for the current operation
// Operands are reduced to magnitudes, processed unsigned for WIDTH steps
// (shift-add or restoring division), and the sign is re-applied at the end.
module alu_iter_multdiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c,
    output logic             overflow_c,
    output logic             dbz
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    logic             busy_q, busy_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic             div_q, div_d;
    logic             dbz_q, dbz_d;
    logic             divovf_q, divovf_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   divisor_x;
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod_s;
    logic [WIDTH-1:0] quo;

    // One iteration per cycle; hi holds product-high / partial remainder,
    // lo holds multiplier / dividend shifting into quotient.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        div_d    = div_q;
        dbz_d    = dbz_q;
        divovf_d = divovf_q;

        addend    = lo_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum       = {1'b0, hi_q} + {1'b0, addend};
        shifted   = {hi_q, lo_q[WIDTH-1]};
        divisor_x = {1'b0, mcand_q};

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = SHW'(WIDTH - 1);
            hi_d     = '0;
            lo_d     = mag(operand_a);
            mcand_d  = mag(operand_b);
            neg_d    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div_d    = op_div;
            dbz_d    = op_div && (operand_b == '0);
            divovf_d = op_div && (operand_a == MIN_VAL) && (operand_b == '1);
        end else if (busy_q) begin
            if (div_q) begin
                if (shifted >= divisor_x) begin
                    hi_d = WIDTH'(shifted - divisor_x);
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - SHW'(1);
            end
        end
    end

    // Sign fix-up from the post-step values so the result is ready on the last step.
    always_comb begin
        prod_mag = {hi_d, lo_d};
        prod_s   = neg_q ? (~prod_mag + PW'(1)) : prod_mag;
        quo      = neg_q ? (~lo_d + WIDTH'(1)) : lo_d;
        if (div_q) begin
            result_c   = dbz_q ? '0 : quo;
            overflow_c = divovf_q;
        end else begin
            result_c   = prod_s[WIDTH-1:0];
            // Upper half plus result sign bit must be all-equal for no overflow.
            overflow_c = !((&prod_s[PW-1:WIDTH-1]) || !(|prod_s[PW-1:WIDTH-1]));
        end
    end

    assign done_c = busy_q && (cnt_q == '0);
    assign dbz    = dbz_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            div_q    <= 1'b0;
            dbz_q    <= 1'b0;
            divovf_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            div_q    <= div_d;
            dbz_q    <= dbz_d;
            divovf_q <= divovf_d;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked execute-stage ALU: single-cycle add/sub/and/or/sll/sra plus
// iterative signed multiply/divide via alu_iter_multdiv_core.
//  clock, reset                 : clock, asynchronous active-high reset
//  in_valid / in_ready          : request handshake (ready only when idle)
//  ctrl_ALUopcode, ctrl_shiftamt: operation and shift amount
//  data_operandA/B              : operands
//  out_valid / out_ready        : result handshake (valid held until taken)
//  data_result                  : registered result
//  isNotEqual, isLessThan       : compare flags from A-B of the accepted operands
//  overflow, exception          : signed overflow; divide-by-zero / illegal opcode
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception
);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             alu_exc;
    logic             is_md;

    logic             md_start;
    logic             md_done_c;
    logic [WIDTH-1:0] md_result_c;
    logic             md_overflow_c;
    logic             md_dbz;

    // Single-cycle datapath on the incoming operands, captured at accept.
    always_comb begin
        sum     = data_operandA + data_operandB;
        diff    = data_operandA - data_operandB;
        add_ovf = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                  (sum[WIDTH-1] != data_operandA[WIDTH-1]);
        sub_ovf = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                  (diff[WIDTH-1] != data_operandA[WIDTH-1]);
        is_md   = (ctrl_ALUopcode == OP_MUL) || (ctrl_ALUopcode == OP_DIV);

        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_exc    = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = add_ovf;
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = sub_ovf;
            end
            OP_AND: alu_result = data_operandA & data_operandB;
            OP_OR:  alu_result = data_operandA | data_operandB;
            OP_SLL: alu_result = data_operandA << ctrl_shiftamt;
            OP_SRA: alu_result = $signed(data_operandA) >>> ctrl_shiftamt;
            OP_MUL, OP_DIV: alu_result = '0;
            default: alu_exc = 1'b1;
        endcase
    end

    // Handshake FSM and output register next-state.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        md_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    flags_d.not_equal = (data_operandA != data_operandB);
                    // Sign of A-B corrected by subtract overflow gives signed A<B.
                    flags_d.less_than = diff[WIDTH-1] ^ sub_ovf;
                    flags_d.overflow  = 1'b0;
                    flags_d.exception = 1'b0;
                    if (is_md) begin
                        md_start = 1'b1;
                        state_d  = ST_BUSY;
                    end else begin
                        result_d          = alu_result;
                        flags_d.overflow  = alu_ovf;
                        flags_d.exception = alu_exc;
                        state_d           = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done_c) begin
                    result_d          = md_result_c;
                    flags_d.overflow  = md_overflow_c;
                    flags_d.exception = md_dbz;
                    state_d           = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    alu_iter_multdiv_core #(
        .WIDTH(WIDTH)
    ) u_multdiv (
        .clock      (clock),
        .reset      (reset),
        .start      (md_start),
        .op_div     (ctrl_ALUopcode == OP_DIV),
        .operand_a  (data_operandA),
        .operand_b  (data_operandB),
        .done_c     (md_done_c),
        .result_c   (md_result_c),
        .overflow_c (md_overflow_c),
        .dbz        (md_dbz)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign data_result = result_q;
    assign isNotEqual  = flags_q.not_equal;
    assign isLessThan  = flags_q.less_than;
    assign overflow    = flags_q.overflow;
    assign exception   = flags_q.exception;

endmodule
